// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared FPU cluster definitions: default widths and the
//                request/response records of the normalize arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int M_DEF     = 23;            // mantissa fraction width
    localparam int E_DEF     = 8;             // exponent width
    localparam int N_DEF     = 4;             // requesters sharing a normalizer
    localparam int TAG_W_DEF = 4;             // opaque tag width

    localparam int MANT_IN_W = 2 * M_DEF + 3; // unnormalized product mantissa
    localparam int EXP_W     = E_DEF + 1;     // exponent with guard bit
    localparam int ID_W      = $clog2(N_DEF);

    typedef struct packed {
        logic [MANT_IN_W-1:0] m;
        logic [EXP_W-1:0]     e;
        logic [TAG_W_DEF-1:0] tag;
    } fp_norm_req_t;

    typedef struct packed {
        logic [M_DEF:0]       m;
        logic [EXP_W-1:0]     e;
        logic                 zero;
        logic [ID_W-1:0]      id;
        logic [TAG_W_DEF-1:0] tag;
    } fp_norm_rsp_t;

endpackage
`default_nettype wire

// File: rtl/fp_normalize.sv
`default_nettype none
// ============================================================================
//  Module      : fp_normalize
//  Description : Combinational mantissa normalizer. Left-justifies the input
//                mantissa by its leading-zero count, keeps the top M+1 bits
//                and lowers the exponent by the same amount (modulo 2^(E+1)).
//                An all-zero mantissa yields m=0, e=0, zero=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_normalize #(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic [2*M+2:0] m,
    input  logic [E:0]     e,
    output logic [M:0]     norm_m,
    output logic [E:0]     norm_e,
    output logic           zero
);

    localparam int MW = 2 * M + 3;
    localparam int EW = E + 1;
    localparam int SW = $clog2(MW + 1);

    logic [SW-1:0] shift;
    logic          found;

    // Leading-zero count: position of the most significant set bit
    always_comb begin
        shift = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && m[i]) begin
                shift = SW'(MW - 1 - i);
                found = 1'b1;
            end
        end
    end

    // Shift, truncate to the hidden-bit-first field and adjust the exponent
    always_comb begin
        zero   = !found;
        norm_m = '0;
        norm_e = '0;
        if (found) begin
            norm_m = (M + 1)'((m << shift) >> (MW - M - 1));
            norm_e = e - EW'(shift);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first active
//                request at or above ptr, wrapping from N-1 to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_any
);

    localparam int IW = $clog2(N);
    localparam logic [IW:0] N_EXT = (IW + 1)'(N);

    logic [IW:0] cand;

    // Priority scan starting at ptr; candidate index wraps modulo N
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW + 1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!grant_any && req[cand[IW-1:0]]) begin
                grant[cand[IW-1:0]] = 1'b1;
                grant_idx           = cand[IW-1:0];
                grant_any           = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_norm_arbiter
//  Description : Round-robin shares one FP normalize datapath between N
//                valid/ready requesters. Stage 1 registers the granted
//                operand, stage 2 the normalized result, returned on a tagged
//                output channel with full backpressure.
//                Optional macro FP_NORM_ARB_PERF_EN adds grant/stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_norm_arbiter
    import fpu_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int M     = M_DEF,
    parameter int E     = E_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_valid,
    output logic [N-1:0]           req_ready,
    input  logic [N*(2*M+3)-1:0]   req_m,
    input  logic [N*(E+1)-1:0]     req_e,
    input  logic [N*TAG_W-1:0]     req_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [M:0]             out_m,
    output logic [E:0]             out_e,
    output logic                   out_zero,
    output logic [$clog2(N)-1:0]   out_id,
    output logic [TAG_W-1:0]       out_tag
`ifdef FP_NORM_ARB_PERF_EN
    ,
    input  logic                   perf_clr,
    output logic [N*32-1:0]        perf_grant_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    localparam int MW = 2 * M + 3;
    localparam int EW = E + 1;
    localparam int IW = $clog2(N);

    logic          adv1, adv2, accept;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_any;
    logic [IW-1:0] rr_ptr;

    logic          s1_valid;
    logic [MW-1:0] s1_m;
    logic [EW-1:0] s1_e;
    logic [TAG_W-1:0] s1_tag;
    logic [IW-1:0] s1_id;

    logic [M:0]    norm_m;
    logic [EW-1:0] norm_e;
    logic          norm_zero;

    rr_arbiter #(.N(N)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Pipeline advance and grant gating; ready is withheld while in reset
    always_comb begin
        adv2      = !out_valid || out_ready;
        adv1      = !s1_valid || adv2;
        accept    = adv1 && grant_any && !rst;
        req_ready = accept ? grant : '0;
    end

    // Round-robin pointer moves past the winner only on an accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    // Stage 1 occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= accept;
        end
    end

    // Stage 1 operand capture from the granted requester
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_m   <= req_m[grant_idx * MW +: MW];
            s1_e   <= req_e[grant_idx * EW +: EW];
            s1_tag <= req_tag[grant_idx * TAG_W +: TAG_W];
            s1_id  <= grant_idx;
        end
    end

    fp_normalize #(.M(M), .E(E)) u_norm (
        .m      (s1_m),
        .e      (s1_e),
        .norm_m (norm_m),
        .norm_e (norm_e),
        .zero   (norm_zero)
    );

    // Stage 2 occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
        end
    end

    // Stage 2 result capture; held while the consumer stalls
    always_ff @(posedge clk) begin
        if (adv2 && s1_valid) begin
            out_m    <= norm_m;
            out_e    <= norm_e;
            out_zero <= norm_zero;
            out_id   <= s1_id;
            out_tag  <= s1_tag;
        end
    end

`ifdef FP_NORM_ARB_PERF_EN
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_perf_grant
            logic [31:0] cnt;
            // Per-requester accept counter
            always_ff @(posedge clk) begin
                if (rst || perf_clr) begin
                    cnt <= '0;
                end else if (req_ready[gi]) begin
                    cnt <= cnt + 32'd1;
                end
            end
            assign perf_grant_cnt[gi*32 +: 32] = cnt;
        end
    endgenerate

    // Output stall cycle counter
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_norm_arbiter
//  Description : Self-checking bench for fp_norm_arbiter (N=4, M=23, E=8):
//                vector table, streaming, stall, reset and perf sequences
//                against a scoreboard of expected responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_norm_arbiter;
    import fpu_pkg::*;

    localparam int N  = 4;
    localparam int MW = 49;
    localparam int EW = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*MW-1:0]   req_m;
    logic [N*EW-1:0]   req_e;
    logic [N*4-1:0]    req_tag;
    logic              out_valid;
    logic              out_ready;
    logic [23:0]       out_m;
    logic [8:0]        out_e;
    logic              out_zero;
    logic [1:0]        out_id;
    logic [3:0]        out_tag;
`ifdef FP_NORM_ARB_PERF_EN
    logic              perf_clr;
    logic [N*32-1:0]   perf_grant_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    logic [MW-1:0] dm [N];
    logic [EW-1:0] de [N];
    logic [3:0]    dt [N];

    int applied     = 0;
    int miscompares = 0;
    fp_norm_rsp_t sb[$];
    int           glog[$];

    always #5 clk = ~clk;

    fp_norm_arbiter #(.N(4), .M(23), .E(8), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_m     (req_m),
        .req_e     (req_e),
        .req_tag   (req_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_m     (out_m),
        .out_e     (out_e),
        .out_zero  (out_zero),
        .out_id    (out_id),
        .out_tag   (out_tag)
`ifdef FP_NORM_ARB_PERF_EN
        ,
        .perf_clr       (perf_clr),
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Pack per-requester operands onto the flat ports
    always_comb begin
        req_m   = '0;
        req_e   = '0;
        req_tag = '0;
        for (int i = 0; i < N; i++) begin
            req_m[i*MW +: MW] = dm[i];
            req_e[i*EW +: EW] = de[i];
            req_tag[i*4 +: 4] = dt[i];
        end
    end

    // Reference normalizer: shift left until the MSB is set
    function automatic fp_norm_rsp_t model(logic [MW-1:0] m, logic [EW-1:0] e, int id, logic [3:0] t);
        fp_norm_rsp_t r;
        int n;
        r.id  = 2'(id);
        r.tag = t;
        if (m == '0) begin
            r.m = '0; r.e = '0; r.zero = 1'b1;
        end else begin
            n = 0;
            while (m[MW-1] == 1'b0) begin
                m = m << 1;
                n++;
            end
            r.m = m[MW-1 -: 24];
            r.e = e - 9'(n);
            r.zero = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] rand_m();
        logic [63:0] r;
        r = {$urandom, $urandom};
        r = r >> $urandom_range(0, 60);
        return r[MW-1:0];
    endfunction

    // Scoreboard: pop on output transfer, push on request transfer
    always @(negedge clk) begin
        fp_norm_rsp_t got;
        fp_norm_rsp_t exp;
        if (rst) begin
            sb.delete();
        end else begin
            chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            if (out_valid && out_ready) begin
                got = '{m: out_m, e: out_e, zero: out_zero, id: out_id, tag: out_tag};
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", 64'(got), 64'hDEAD);
                end else begin
                    exp = sb.pop_front();
                    chk("out_rsp", 64'(got), 64'(exp));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back(model(dm[i], de[i], i, dt[i]));
                    glog.push_back(i);
                end
            end
        end
    end

    task automatic send_one(int i, logic [MW-1:0] m, logic [EW-1:0] e, logic [3:0] t);
        bit ok;
        dm[i] = m; de[i] = e; dt[i] = t;
        req_valid = 4'(1 << i);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[i]) ok = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = '0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        req_valid = '0;
        out_ready = 1'b1;
        n = 0;
        while ((out_valid || sb.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    // Continuous requests on all lanes; out_ready low for [stall_start, +stall_len)
    task automatic stream(int cycles, int stall_start, int stall_len);
        logic [N-1:0] acc;
        logic [40:0]  held;
        held = '0;
        req_valid = '1;
        for (int c = 0; c < cycles; c++) begin
            out_ready = !(c >= stall_start && c < stall_start + stall_len);
            @(negedge clk);
            acc = req_valid & req_ready;
            if (c == stall_start) begin
                held = {out_valid, out_m, out_e, out_zero, out_id, out_tag};
            end else if (c > stall_start && c < stall_start + stall_len) begin
                chk("stall_ready_low", 64'(req_ready), 64'd0);
                chk("stall_out_hold", 64'({out_valid, out_m, out_e, out_zero, out_id, out_tag}), 64'(held));
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    dm[i] = rand_m(); de[i] = 9'($urandom); dt[i] = 4'($urandom);
                end
            end
        end
    endtask

    typedef struct {
        int             req;
        logic [MW-1:0]  m;
        logic [EW-1:0]  e;
        logic [3:0]     tag;
        logic [23:0]    xm;
        logic [EW-1:0]  xe;
        logic           xz;
    } vec_t;

    initial begin
        vec_t vt[8];
        // 2^24 in a 49-bit field: 24 leading zeros -> e = 150-24
        vt[0] = '{0, 49'h0_0000_0100_0000, 9'd150, 4'd3, 24'h800000, 9'd126, 1'b0};
        vt[1] = '{2, 49'h0,                9'd10,  4'd5, 24'h000000, 9'd0,   1'b1};
        // LSB only: 48 leading zeros, 5-48 wraps to 469
        vt[2] = '{1, 49'h0_0000_0000_0001, 9'd5,   4'd7, 24'h800000, 9'd469, 1'b0};
        vt[3] = '{3, 49'h1_0000_0000_0000, 9'd511, 4'd1, 24'h800000, 9'd511, 1'b0};
        vt[4] = '{0, 49'h1_FFFF_FFFF_FFFF, 9'd0,   4'd2, 24'hFFFFFF, 9'd0,   1'b0};
        vt[5] = '{1, 49'h0_0000_0000_0003, 9'd100, 4'd9, 24'hC00000, 9'd53,  1'b0};
        vt[6] = '{2, 49'h1_0000_0000_0001, 9'd20,  4'hE, 24'h800000, 9'd20,  1'b0};
        vt[7] = '{3, 49'h0_0000_0200_0000, 9'd3,   4'hF, 24'h800000, 9'd492, 1'b0};

        for (int i = 0; i < N; i++) begin
            dm[i] = '0; de[i] = '0; dt[i] = '0;
        end
        rst = 1'b1;
        req_valid = '1;
        out_ready = 1'b1;
`ifdef FP_NORM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors: single request, fixed latency, direct field checks
        for (int v = 0; v < 8; v++) begin
            send_one(vt[v].req, vt[v].m, vt[v].e, vt[v].tag);
            chk("lat_stage1", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            chk("lat_out_valid", 64'(out_valid), 64'd1);
            chk("vec_m_e_zero", 64'({out_m, out_e, out_zero}), 64'({vt[v].xm, vt[v].xe, vt[v].xz}));
            chk("vec_id_tag", 64'({out_id, out_tag}), 64'({2'(vt[v].req), vt[v].tag}));
            @(posedge clk); #1;
        end

        // Full-rate streaming: one grant per cycle, strict rotation from 0
        for (int i = 0; i < N; i++) begin
            dm[i] = rand_m(); de[i] = 9'($urandom); dt[i] = 4'($urandom);
        end
        glog.delete();
        stream(12, 1000, 0);
        chk("stream_grant_count", 64'(glog.size()), 64'd12);
        for (int k = 0; k < 12 && k < glog.size(); k++) begin
            chk("grant_order", 64'(glog[k]), 64'(k % 4));
        end

        // Five-cycle stall in the middle of streaming
        stream(16, 4, 5);
        drain();

        // Reset with both stages full
        req_valid = '1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("prerst_full", 64'({out_valid, req_ready}), 64'({1'b1, 4'b0000}));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = 4'b1010;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("postrst_first_grant", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        drain();

`ifdef FP_NORM_ARB_PERF_EN
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
        out_ready = 1'b0;
        send_one(1, rand_m(), 9'd7, 4'd1);
        for (int n = 0; n < 10 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) send_one(1, rand_m(), 9'(k), 4'(k));
        drain();
        chk("perf_grant1", 64'(perf_grant_cnt[32 +: 32]), 64'd10);
        chk("perf_grant0", 64'(perf_grant_cnt[0 +: 32]), 64'd0);
        chk("perf_stall", 64'(perf_stall_cnt), 64'd3);
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
        chk("perf_clr_grant", 64'(perf_grant_cnt), 64'd0);
        chk("perf_clr_stall", 64'(perf_stall_cnt), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
